// File: rtl/ocp_mem_arbiter.sv
// Two-master OCP arbiter in front of a single memory slave: round-robin grant,
// one outstanding transaction, and an ERR response if the slave never answers.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef BEN_WIDTH
`define BEN_WIDTH 4
`endif
`ifndef OCP_CMD_IDLE
`define OCP_CMD_IDLE 3'b000
`endif
`ifndef OCP_CMD_WRITE
`define OCP_CMD_WRITE 3'b001
`endif
`ifndef OCP_CMD_READ
`define OCP_CMD_READ 3'b010
`endif
`ifndef OCP_RESP_NULL
`define OCP_RESP_NULL 2'b00
`endif
`ifndef OCP_RESP_DVA
`define OCP_RESP_DVA 2'b01
`endif
`ifndef OCP_RESP_ERR
`define OCP_RESP_ERR 2'b11
`endif

module ocp_mem_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [`ADDR_WIDTH-1:0]  m0_MAddr,
    input  logic [2:0]              m0_MCmd,
    input  logic [`DATA_WIDTH-1:0]  m0_MData,
    input  logic [`BEN_WIDTH-1:0]   m0_MByteEn,
    output logic                    m0_SCmdAccept,
    output logic [`DATA_WIDTH-1:0]  m0_SData,
    output logic [1:0]              m0_SResp,
    input  logic [`ADDR_WIDTH-1:0]  m1_MAddr,
    input  logic [2:0]              m1_MCmd,
    input  logic [`DATA_WIDTH-1:0]  m1_MData,
    input  logic [`BEN_WIDTH-1:0]   m1_MByteEn,
    output logic                    m1_SCmdAccept,
    output logic [`DATA_WIDTH-1:0]  m1_SData,
    output logic [1:0]              m1_SResp,
    output logic [`ADDR_WIDTH-1:0]  s_MAddr,
    output logic [2:0]              s_MCmd,
    output logic [`DATA_WIDTH-1:0]  s_MData,
    output logic [`BEN_WIDTH-1:0]   s_MByteEn,
    input  logic                    s_SCmdAccept,
    input  logic [`DATA_WIDTH-1:0]  s_SData,
    input  logic [1:0]              s_SResp
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_WAIT = 1'b1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic          state_reg, state_next;
    logic          last_reg, last_next;
    logic          owner_reg, owner_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          hold_valid_reg, hold_valid_next;
    logic          hold_sel_reg, hold_sel_next;

    logic req0, req1, gnt_valid, gnt_sel, issue, resp_valid, timeout_hit;

    logic [`ADDR_WIDTH-1:0] m_addr  [2];
    logic [2:0]             m_cmd   [2];
    logic [`DATA_WIDTH-1:0] m_wdata [2];
    logic [`BEN_WIDTH-1:0]  m_ben   [2];
    logic [1:0]             m_acc;
    logic [1:0]             m_resp  [2];
    logic [`DATA_WIDTH-1:0] m_rdata [2];

    assign m_addr[0]  = m0_MAddr;
    assign m_addr[1]  = m1_MAddr;
    assign m_cmd[0]   = m0_MCmd;
    assign m_cmd[1]   = m1_MCmd;
    assign m_wdata[0] = m0_MData;
    assign m_wdata[1] = m1_MData;
    assign m_ben[0]   = m0_MByteEn;
    assign m_ben[1]   = m1_MByteEn;

    assign req0        = (m0_MCmd != `OCP_CMD_IDLE);
    assign req1        = (m1_MCmd != `OCP_CMD_IDLE);
    assign gnt_valid   = req0 | req1;
    assign resp_valid  = (s_SResp != `OCP_RESP_NULL);
    assign timeout_hit = (cnt_reg == CNT_LAST);
    assign issue       = !rst && (state_reg == ST_IDLE) && gnt_valid;

    // A stalled grant sticks to its master until accepted or withdrawn, even
    // if the other master starts requesting and round-robin would prefer it.
    always_comb begin
        gnt_sel = 1'b0;
        if (hold_valid_reg && (hold_sel_reg ? req1 : req0)) begin
            gnt_sel = hold_sel_reg;
        end else if (req0 && req1) begin
            gnt_sel = ~last_reg;
        end else begin
            gnt_sel = req1;
        end
    end

    assign s_MAddr   = issue ? m_addr[gnt_sel]  : '0;
    assign s_MCmd    = issue ? m_cmd[gnt_sel]   : `OCP_CMD_IDLE;
    assign s_MData   = issue ? m_wdata[gnt_sel] : '0;
    assign s_MByteEn = issue ? m_ben[gnt_sel]   : '0;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_master
            logic owned;
            assign owned = !rst && (state_reg == ST_WAIT) && (owner_reg == 1'(gi));
            assign m_acc[gi] = issue && (gnt_sel == 1'(gi)) && s_SCmdAccept;
            // A real slave response always wins over a timeout in the same cycle.
            assign m_resp[gi] = !owned     ? `OCP_RESP_NULL :
                                resp_valid ? s_SResp :
                                timeout_hit ? `OCP_RESP_ERR : `OCP_RESP_NULL;
            assign m_rdata[gi] = (owned && resp_valid) ? s_SData : '0;
        end
    endgenerate

    assign m0_SCmdAccept = m_acc[0];
    assign m1_SCmdAccept = m_acc[1];
    assign m0_SResp      = m_resp[0];
    assign m1_SResp      = m_resp[1];
    assign m0_SData      = m_rdata[0];
    assign m1_SData      = m_rdata[1];

    always_comb begin
        state_next      = state_reg;
        last_next       = last_reg;
        owner_next      = owner_reg;
        cnt_next        = cnt_reg;
        hold_valid_next = hold_valid_reg;
        hold_sel_next   = hold_sel_reg;
        if (state_reg == ST_IDLE) begin
            if (gnt_valid) begin
                if (s_SCmdAccept) begin
                    owner_next      = gnt_sel;
                    cnt_next        = '0;
                    state_next      = ST_WAIT;
                    hold_valid_next = 1'b0;
                end else begin
                    hold_valid_next = 1'b1;
                    hold_sel_next   = gnt_sel;
                end
            end else begin
                hold_valid_next = 1'b0;
            end
        end else begin
            if (resp_valid || timeout_hit) begin
                last_next  = owner_reg;
                cnt_next   = '0;
                state_next = ST_IDLE;
            end else begin
                cnt_next = cnt_reg + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            last_reg       <= 1'b1;
            owner_reg      <= 1'b0;
            cnt_reg        <= '0;
            hold_valid_reg <= 1'b0;
            hold_sel_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            last_reg       <= last_next;
            owner_reg      <= owner_next;
            cnt_reg        <= cnt_next;
            hold_valid_reg <= hold_valid_next;
            hold_sel_reg   <= hold_sel_next;
        end
    end

endmodule

// File: tb/tb_ocp_mem_arbiter.sv
// Bench for ocp_mem_arbiter: a 1-cycle memory slave model plus a scoreboard of
// expected responses, exercised by one task per scenario.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef BEN_WIDTH
`define BEN_WIDTH 4
`endif
`ifndef OCP_CMD_IDLE
`define OCP_CMD_IDLE 3'b000
`endif
`ifndef OCP_CMD_WRITE
`define OCP_CMD_WRITE 3'b001
`endif
`ifndef OCP_CMD_READ
`define OCP_CMD_READ 3'b010
`endif
`ifndef OCP_RESP_NULL
`define OCP_RESP_NULL 2'b00
`endif
`ifndef OCP_RESP_DVA
`define OCP_RESP_DVA 2'b01
`endif
`ifndef OCP_RESP_ERR
`define OCP_RESP_ERR 2'b11
`endif

module tb_ocp_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst;
    logic [`ADDR_WIDTH-1:0] m0_MAddr, m1_MAddr, s_MAddr;
    logic [2:0]             m0_MCmd, m1_MCmd, s_MCmd;
    logic [`DATA_WIDTH-1:0] m0_MData, m1_MData, s_MData;
    logic [`BEN_WIDTH-1:0]  m0_MByteEn, m1_MByteEn, s_MByteEn;
    logic                   m0_SCmdAccept, m1_SCmdAccept, s_SCmdAccept;
    logic [`DATA_WIDTH-1:0] m0_SData, m1_SData, s_SData;
    logic [1:0]             m0_SResp, m1_SResp, s_SResp;

    ocp_mem_arbiter #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .m0_MAddr(m0_MAddr), .m0_MCmd(m0_MCmd), .m0_MData(m0_MData), .m0_MByteEn(m0_MByteEn),
        .m0_SCmdAccept(m0_SCmdAccept), .m0_SData(m0_SData), .m0_SResp(m0_SResp),
        .m1_MAddr(m1_MAddr), .m1_MCmd(m1_MCmd), .m1_MData(m1_MData), .m1_MByteEn(m1_MByteEn),
        .m1_SCmdAccept(m1_SCmdAccept), .m1_SData(m1_SData), .m1_SResp(m1_SResp),
        .s_MAddr(s_MAddr), .s_MCmd(s_MCmd), .s_MData(s_MData), .s_MByteEn(s_MByteEn),
        .s_SCmdAccept(s_SCmdAccept), .s_SData(s_SData), .s_SResp(s_SResp)
    );

    // Memory slave: responds one cycle after accept; can be muted or overridden.
    logic        slv_accept, slv_mute, inject;
    logic [1:0]  slv_resp;
    logic [31:0] slv_data;
    logic [31:0] slv_mem [0:63];
    logic [31:0] ref_mem [0:63];

    assign s_SCmdAccept = slv_accept;
    assign s_SResp      = inject ? `OCP_RESP_DVA : slv_resp;
    assign s_SData      = inject ? 32'hDEADBEEF : slv_data;

    always @(posedge clk) begin
        if (rst) begin
            slv_resp <= `OCP_RESP_NULL;
            slv_data <= '0;
        end else begin
            slv_resp <= `OCP_RESP_NULL;
            slv_data <= '0;
            if (s_MCmd != `OCP_CMD_IDLE && s_SCmdAccept && !slv_mute) begin
                slv_resp <= `OCP_RESP_DVA;
                if (s_MCmd == `OCP_CMD_READ) begin
                    slv_data <= slv_mem[s_MAddr[7:2]];
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (s_MByteEn[b]) slv_mem[s_MAddr[7:2]][8*b +: 8] <= s_MData[8*b +: 8];
                end
            end
        end
    end

    typedef struct packed {
        logic        m;
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    task automatic drive(input logic m, input logic [2:0] cmd, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] ben);
        if (m) begin
            m1_MCmd = cmd; m1_MAddr = addr; m1_MData = wdata; m1_MByteEn = ben;
        end else begin
            m0_MCmd = cmd; m0_MAddr = addr; m0_MData = wdata; m0_MByteEn = ben;
        end
    endtask

    // Issues one command and returns what the masters observed; called just after a rising edge.
    task automatic do_txn(input logic m, input logic [2:0] cmd, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] ben,
                          output logic ok, output logic [1:0] resp, output logic [31:0] rdata,
                          output logic [1:0] oth_resp, output logic [31:0] oth_data);
        exp_t x;
        x.m = m;
        x.resp = `OCP_RESP_DVA;
        x.data = (cmd == `OCP_CMD_READ) ? ref_mem[addr[7:2]] : 32'h0;
        if (cmd == `OCP_CMD_WRITE)
            for (int b = 0; b < 4; b++)
                if (ben[b]) ref_mem[addr[7:2]][8*b +: 8] = wdata[8*b +: 8];
        sb.push_back(x);
        drive(m, cmd, addr, wdata, ben);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m ? m1_SCmdAccept : m0_SCmdAccept) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        drive(m, `OCP_CMD_IDLE, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        resp     = m ? m1_SResp : m0_SResp;
        rdata    = m ? m1_SData : m0_SData;
        oth_resp = m ? m0_SResp : m1_SResp;
        oth_data = m ? m0_SData : m1_SData;
        $display("txn m%0d cmd %0d addr %h accepted %0d resp %0d data %h", m, cmd, addr, ok, resp, rdata);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; slv_accept = 1'b1; slv_mute = 1'b0; inject = 1'b1;
        drive(1'b0, `OCP_CMD_READ, 32'h10, 32'h0, 4'hF);
        drive(1'b1, `OCP_CMD_WRITE, 32'h20, 32'h1, 4'hF);
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({m0_SCmdAccept, m1_SCmdAccept} !== 2'b00) begin
            errors++; $display("FAIL reset_accept got %b expected 00", {m0_SCmdAccept, m1_SCmdAccept});
        end
        checks++;
        if ({m0_SResp, m1_SResp} !== 4'b0000 || m0_SData !== 32'h0 || m1_SData !== 32'h0) begin
            errors++; $display("FAIL reset_resp got %h/%h %h/%h expected 0", m0_SResp, m0_SData, m1_SResp, m1_SData);
        end
        checks++;
        if (s_MCmd !== `OCP_CMD_IDLE) begin
            errors++; $display("FAIL reset_smcmd got %0d expected 0", s_MCmd);
        end
        @(posedge clk); #1;
        rst = 1'b0; inject = 1'b0;
        drive(1'b0, `OCP_CMD_IDLE, 32'h0, 32'h0, 4'h0);
        drive(1'b1, `OCP_CMD_IDLE, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        checks++;
        if (s_MCmd !== `OCP_CMD_IDLE || {m0_SCmdAccept, m1_SCmdAccept} !== 2'b00) begin
            errors++; $display("FAIL idle_no_req got cmd %0d acc %b expected 0 00", s_MCmd, {m0_SCmdAccept, m1_SCmdAccept});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_read();
        logic ok; logic [1:0] r, orr; logic [31:0] d, od;
        slv_mem[4] = 32'h12345678;
        ref_mem[4] = 32'h12345678;
        do_txn(1'b0, `OCP_CMD_READ, 32'h10, 32'h0, 4'hF, ok, r, d, orr, od);
        e = sb.pop_front();
        checks++;
        if (ok !== 1'b1) begin errors++; $display("FAIL read_accept got %b expected 1", ok); end
        checks++;
        if (r !== e.resp || d !== e.data) begin
            errors++; $display("FAIL read_resp got %0d %h expected %0d %h", r, d, e.resp, e.data);
        end
        checks++;
        if (d !== 32'h12345678) begin errors++; $display("FAIL read_word4 got %h expected 12345678", d); end
        checks++;
        if (orr !== `OCP_RESP_NULL || od !== 32'h0) begin
            errors++; $display("FAIL read_other got %0d %h expected 0 0", orr, od);
        end
    endtask

    task automatic test_write_read();
        logic ok; logic [1:0] r, orr; logic [31:0] d, od;
        do_txn(1'b1, `OCP_CMD_WRITE, 32'h20, 32'hCAFEBABE, 4'h3, ok, r, d, orr, od);
        e = sb.pop_front();
        checks++;
        if (ok !== 1'b1 || r !== e.resp || orr !== `OCP_RESP_NULL) begin
            errors++; $display("FAIL write_resp got acc %b resp %0d other %0d expected 1 %0d 0", ok, r, orr, e.resp);
        end
        do_txn(1'b0, `OCP_CMD_READ, 32'h20, 32'h0, 4'hF, ok, r, d, orr, od);
        e = sb.pop_front();
        checks++;
        if (ok !== 1'b1 || r !== e.resp || d !== e.data) begin
            errors++; $display("FAIL readback got acc %b %0d %h expected 1 %0d %h", ok, r, d, e.resp, e.data);
        end
        checks++;
        if (d !== 32'h0000BABE) begin errors++; $display("FAIL readback_val got %h expected 0000babe", d); end
    endtask

    task automatic test_timeout();
        int k;
        slv_mute = 1'b1;
        drive(1'b0, `OCP_CMD_READ, 32'h10, 32'h0, 4'hF);
        @(negedge clk);
        checks++;
        if (m0_SCmdAccept !== 1'b1) begin errors++; $display("FAIL to_accept got %b expected 1", m0_SCmdAccept); end
        sb.push_back('{m: 1'b0, resp: `OCP_RESP_ERR, data: 32'h0});
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (i == 1) drive(1'b0, `OCP_CMD_IDLE, 32'h0, 32'h0, 4'h0);
            @(negedge clk);
            if (m0_SResp !== `OCP_RESP_NULL) begin k = i; break; end
        end
        $display("txn m0 timeout after %0d cycles resp %0d data %h", k, m0_SResp, m0_SData);
        e = sb.pop_front();
        checks++;
        if (k != 16) begin errors++; $display("FAIL to_latency got %0d expected 16", k); end
        checks++;
        if (m0_SResp !== e.resp || m0_SData !== e.data || m1_SResp !== `OCP_RESP_NULL) begin
            errors++; $display("FAIL to_err got %0d %h other %0d expected %0d %h 0", m0_SResp, m0_SData, m1_SResp, e.resp, e.data);
        end
        @(posedge clk); #1;
        inject = 1'b1;
        @(negedge clk);
        checks++;
        if (m0_SResp !== `OCP_RESP_NULL || m1_SResp !== `OCP_RESP_NULL || m0_SData !== 32'h0) begin
            errors++; $display("FAIL to_stray got %0d %0d %h expected 0 0 0", m0_SResp, m1_SResp, m0_SData);
        end
        @(posedge clk); #1;
        inject = 1'b0;
        // Slave answers in the very cycle the timeout would fire.
        drive(1'b0, `OCP_CMD_READ, 32'h10, 32'h0, 4'hF);
        sb.push_back('{m: 1'b0, resp: `OCP_RESP_DVA, data: 32'hDEADBEEF});
        @(negedge clk);
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            if (i == 1) drive(1'b0, `OCP_CMD_IDLE, 32'h0, 32'h0, 4'h0);
            if (i == 16) inject = 1'b1;
            @(negedge clk);
            if (i == 15) begin
                checks++;
                if (m0_SResp !== `OCP_RESP_NULL) begin errors++; $display("FAIL to_early got %0d expected 0", m0_SResp); end
            end
        end
        e = sb.pop_front();
        checks++;
        if (m0_SResp !== e.resp || m0_SData !== e.data) begin
            errors++; $display("FAIL to_tie got %0d %h expected %0d %h", m0_SResp, m0_SData, e.resp, e.data);
        end
        @(posedge clk); #1;
        inject = 1'b0; slv_mute = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_acc;
        logic [1:0] r; logic [31:0] d;
        rst = 1'b1;
        drive(1'b0, `OCP_CMD_READ, 32'h10, 32'h0, 4'hF);
        drive(1'b1, `OCP_CMD_READ, 32'h20, 32'h0, 4'hF);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            exp_acc = (c == 0 || c == 4) ? 2'b10 : (c == 2 || c == 6) ? 2'b01 : 2'b00;
            if (exp_acc != 2'b00)
                sb.push_back('{m: exp_acc[0], resp: `OCP_RESP_DVA,
                               data: exp_acc[0] ? ref_mem[8] : ref_mem[4]});
            @(negedge clk);
            checks++;
            if ({m0_SCmdAccept, m1_SCmdAccept} !== exp_acc) begin
                errors++; $display("FAIL rr_grant c%0d got %b expected %b", c, {m0_SCmdAccept, m1_SCmdAccept}, exp_acc);
            end
            if (c % 2 == 1 && sb.size() > 0) begin
                e = sb.pop_front();
                r = e.m ? m1_SResp : m0_SResp;
                d = e.m ? m1_SData : m0_SData;
                $display("txn m%0d rr cycle %0d resp %0d data %h", e.m, c, r, d);
                checks++;
                if (r !== e.resp || d !== e.data) begin
                    errors++; $display("FAIL rr_resp c%0d got %0d %h expected %0d %h", c, r, d, e.resp, e.data);
                end
            end
            @(posedge clk); #1;
        end
        drive(1'b0, `OCP_CMD_IDLE, 32'h0, 32'h0, 4'h0);
        drive(1'b1, `OCP_CMD_IDLE, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic test_accept_stall();
        slv_accept = 1'b0;
        slv_mem[9] = 32'hA5A5_0009;
        ref_mem[9] = 32'hA5A5_0009;
        drive(1'b1, `OCP_CMD_READ, 32'h24, 32'h0, 4'hF);
        for (int c = 0; c < 3; c++) begin
            if (c == 1) drive(1'b0, `OCP_CMD_READ, 32'h28, 32'h0, 4'hF);
            @(negedge clk);
            checks++;
            if (s_MAddr !== 32'h24 || {m0_SCmdAccept, m1_SCmdAccept} !== 2'b00) begin
                errors++; $display("FAIL stall c%0d got addr %h acc %b expected 24 00", c, s_MAddr, {m0_SCmdAccept, m1_SCmdAccept});
            end
            @(posedge clk); #1;
        end
        slv_accept = 1'b1;
        sb.push_back('{m: 1'b1, resp: `OCP_RESP_DVA, data: ref_mem[9]});
        @(negedge clk);
        checks++;
        if ({m0_SCmdAccept, m1_SCmdAccept} !== 2'b01) begin
            errors++; $display("FAIL stall_release got %b expected 01", {m0_SCmdAccept, m1_SCmdAccept});
        end
        @(posedge clk); #1;
        drive(1'b0, `OCP_CMD_IDLE, 32'h0, 32'h0, 4'h0);
        drive(1'b1, `OCP_CMD_IDLE, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        e = sb.pop_front();
        $display("txn m1 stalled read resp %0d data %h", m1_SResp, m1_SData);
        checks++;
        if (m1_SResp !== e.resp || m1_SData !== e.data || m0_SResp !== `OCP_RESP_NULL) begin
            errors++; $display("FAIL stall_resp got %0d %h other %0d expected %0d %h 0", m1_SResp, m1_SData, m0_SResp, e.resp, e.data);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_in_wait();
        logic ok; logic [1:0] r, orr; logic [31:0] d, od;
        do_txn(1'b0, `OCP_CMD_READ, 32'h10, 32'h0, 4'hF, ok, r, d, orr, od);
        e = sb.pop_front();
        checks++;
        if (ok !== 1'b1 || r !== e.resp || d !== e.data) begin
            errors++; $display("FAIL rw_pre got %b %0d %h expected 1 %0d %h", ok, r, d, e.resp, e.data);
        end
        slv_mute = 1'b1;
        drive(1'b1, `OCP_CMD_READ, 32'h20, 32'h0, 4'hF);
        @(negedge clk);
        checks++;
        if (m1_SCmdAccept !== 1'b1) begin errors++; $display("FAIL rw_accept got %b expected 1", m1_SCmdAccept); end
        @(posedge clk); #1;
        drive(1'b1, `OCP_CMD_IDLE, 32'h0, 32'h0, 4'h0);
        @(posedge clk); #1;
        rst = 1'b1; inject = 1'b1;
        drive(1'b0, `OCP_CMD_READ, 32'h10, 32'h0, 4'hF);
        drive(1'b1, `OCP_CMD_READ, 32'h20, 32'h0, 4'hF);
        @(negedge clk);
        checks++;
        if ({m0_SCmdAccept, m1_SCmdAccept, m0_SResp, m1_SResp} !== 6'b0 || m0_SData !== 32'h0 ||
            m1_SData !== 32'h0 || s_MCmd !== `OCP_CMD_IDLE) begin
            errors++; $display("FAIL rw_during_rst got acc %b resp %0d %0d cmd %0d expected all 0",
                               {m0_SCmdAccept, m1_SCmdAccept}, m0_SResp, m1_SResp, s_MCmd);
        end
        @(posedge clk); #1;
        rst = 1'b0; inject = 1'b0; slv_mute = 1'b0;
        sb.push_back('{m: 1'b0, resp: `OCP_RESP_DVA, data: ref_mem[4]});
        @(negedge clk);
        checks++;
        if ({m0_SCmdAccept, m1_SCmdAccept} !== 2'b10 || m1_SResp !== `OCP_RESP_NULL) begin
            errors++; $display("FAIL rw_regrant got %b m1resp %0d expected 10 0", {m0_SCmdAccept, m1_SCmdAccept}, m1_SResp);
        end
        @(posedge clk); #1;
        drive(1'b0, `OCP_CMD_IDLE, 32'h0, 32'h0, 4'h0);
        drive(1'b1, `OCP_CMD_IDLE, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        e = sb.pop_front();
        $display("txn m0 after reset resp %0d data %h", m0_SResp, m0_SData);
        checks++;
        if (m0_SResp !== e.resp || m0_SData !== e.data) begin
            errors++; $display("FAIL rw_resp got %0d %h expected %0d %h", m0_SResp, m0_SData, e.resp, e.data);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            slv_mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        test_reset();
        test_single_read();
        test_write_read();
        test_timeout();
        test_round_robin();
        test_accept_stall();
        test_reset_in_wait();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d expected 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ocp_mem_arbiter.md
OCP_MEM_ARBITER -- requirements
Module: ocp_mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of WAIT cycles allowed before the arbiter answers with an error response.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port m0_MAddr, input, `ADDR_WIDTH: master 0 address.
REQ-005 SHALL have port m0_MCmd, input, 3 bits: master 0 command (IDLE/WRITE/READ per ocp_const.vh).
REQ-006 SHALL have port m0_MData, input, `DATA_WIDTH: master 0 write data.
REQ-007 SHALL have port m0_MByteEn, input, `BEN_WIDTH: master 0 byte enables.
REQ-008 SHALL have port m0_SCmdAccept, output, 1 bit: command accepted for master 0.
REQ-009 SHALL have port m0_SData, output, `DATA_WIDTH: master 0 read data.
REQ-010 SHALL have port m0_SResp, output, 2 bits: master 0 response.
REQ-011 SHALL have ports m1_MAddr, m1_MCmd, m1_MData, m1_MByteEn, m1_SCmdAccept, m1_SData and m1_SResp, identical in direction, width and meaning to the m0 set, for master 1.
REQ-012 SHALL have ports s_MAddr, s_MCmd, s_MData and s_MByteEn, outputs of the same widths as the m0 inputs: the command to the shared memory slave.
REQ-013 SHALL have ports s_SCmdAccept (input, 1 bit), s_SData (input, `DATA_WIDTH) and s_SResp (input, 2 bits): the shared slave's accept, read data and response.

Function
REQ-014 SHALL implement a two-state FSM with states IDLE and WAIT, plus a 1-bit last-served register (last) and a wait counter (cnt) of width clog2(TIMEOUT+1).
REQ-015 In IDLE, a master is "requesting" when its MCmd != `OCP_CMD_IDLE.
REQ-016 In IDLE, the grant SHALL go to the sole requester, or, if both request, to the master != last (round-robin).
REQ-017 In IDLE, s_MAddr, s_MCmd, s_MData and s_MByteEn SHALL combinationally mirror the granted master's inputs.
REQ-018 In IDLE, the granted master's SCmdAccept SHALL equal s_SCmdAccept, and the other master's SCmdAccept SHALL be 0.
REQ-019 In IDLE with no requester, s_MCmd SHALL be `OCP_CMD_IDLE and both SCmdAccepts SHALL be 0.
REQ-020 An IDLE cycle with a grant and s_SCmdAccept=1 SHALL latch owner=granted master, clear cnt, and move to WAIT.
REQ-021 An IDLE cycle with a grant and s_SCmdAccept=0 SHALL keep the grant unchanged next cycle; last is not updated and the grant is not re-arbitrated while the request holds.
REQ-022 In WAIT, s_MCmd SHALL be `OCP_CMD_IDLE and both SCmdAccepts SHALL be 0 (one outstanding transaction maximum).
REQ-023 In WAIT, when s_SResp != `OCP_RESP_NULL, owner SResp and SData SHALL combinationally equal s_SResp and s_SData; then last=owner and the next state is IDLE.
REQ-024 In WAIT, when s_SResp is NULL, cnt SHALL increment.
REQ-025 In WAIT, when s_SResp is NULL and cnt==TIMEOUT-1, owner SResp SHALL be `OCP_RESP_ERR and SData 0 for that cycle; then last=owner and the next state is IDLE.
REQ-026 A response and the timeout in the same cycle SHALL forward the slave response, not ERR.
REQ-027 The non-owner master, and both masters in IDLE, SHALL see SResp=`OCP_RESP_NULL and SData=0.
REQ-028 A non-NULL s_SResp arriving in IDLE (late or stray) SHALL be dropped and not forwarded.
REQ-029 With the 1-cycle memory slave, per-transaction latency SHALL be accept at cycle N, response at cycle N+1, next grant possible at cycle N+2.

Reset
REQ-030 While rst=1 at a clock edge, the next state SHALL be: FSM=IDLE, cnt=0, last=1 (master 0 wins first contention), owner=0.
REQ-031 While rst=1, all SCmdAccepts SHALL be 0, all SResp `OCP_RESP_NULL, all SData 0, and s_MCmd `OCP_CMD_IDLE, regardless of inputs.
REQ-032 rst asserted in WAIT SHALL abandon the outstanding transaction with no response delivered; any slave response arriving after reset is dropped per REQ-028.

Verification
REQ-033 SHALL cover: m0 READ 0x10 alone, memory word 4 = 0x12345678 -> m0_SCmdAccept=1 at cycle N, m0_SResp=DVA and m0_SData=0x12345678 at N+1, m1 outputs NULL/0.
REQ-034 SHALL cover: m0 and m1 request continuously after reset -> grants m0,m1,m0,m1 on cycles 0,2,4,6 after reset.
REQ-035 SHALL cover: m1 WRITE 0xCAFEBABE with MByteEn=0x3 to 0x20, then m0 READ 0x20 (word previously 0) -> m0 reads 0x0000BABE.
REQ-036 SHALL cover: slave s_SResp held NULL after accept, TIMEOUT=16 -> owner SResp=ERR exactly 16 cycles after accept; a DVA injected one cycle later is not forwarded.
REQ-037 SHALL cover: s_SCmdAccept=0 for 3 cycles while both masters request -> the granted master stays granted, the other sees SCmdAccept=0 throughout.
REQ-038 SHALL cover: rst pulsed in WAIT -> all outputs NULL/0 during reset, and the next contention is granted to m0.
